// File: rtl/four_bit_loader.sv
// ============================================================================
// Module  : four_bit_loader
// Purpose : Boot loader and run controller for the four_bit_comp CPU.
//           Streams a 16-word image into the CPU memories while holding it
//           in reset, runs it for RUN_CYCLES cycles, then freezes it and
//           captures data_out as the result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module four_bit_loader #(
  parameter int RUN_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_data,
  output logic        cpu_reset,
  output logic [3:0]  prog_count,
  output logic [3:0]  prog_inst,
  output logic [3:0]  prog_data,
  output logic [3:0]  data_in,
  input  logic [3:0]  cpu_data_out,
  output logic        busy,
  output logic        done,
  output logic [3:0]  result
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_load  = 3'd1;
  localparam logic [2:0] c_flush = 3'd2;
  localparam logic [2:0] c_run   = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

  // Counter value seen on the final run edge; that edge captures the result.
  localparam logic [15:0] c_run_last = 16'(RUN_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [3:0]  prog_count_q, prog_count_d;
  logic [3:0]  prog_inst_q, prog_inst_d;
  logic [3:0]  prog_data_q, prog_data_d;
  logic [3:0]  data_in_q, data_in_d;
  logic [3:0]  result_q, result_d;
  logic        w_handshake;

  // Handshake is derived from the registered state so s_ready stays glitch-free.
  assign w_handshake = (state_q == c_load) && s_valid;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= c_idle;
      idx_q        <= 4'd0;
      run_cnt_q    <= 16'd0;
      prog_count_q <= 4'd0;
      prog_inst_q  <= 4'd0;
      prog_data_q  <= 4'd0;
      data_in_q    <= 4'd0;
      result_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_cnt_q    <= run_cnt_d;
      prog_count_q <= prog_count_d;
      prog_inst_q  <= prog_inst_d;
      prog_data_q  <= prog_data_d;
      data_in_q    <= data_in_d;
      result_q     <= result_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    run_cnt_d    = run_cnt_q;
    prog_count_d = prog_count_q;
    prog_inst_d  = prog_inst_q;
    prog_data_d  = prog_data_q;
    data_in_d    = data_in_q;
    result_d     = result_q;
    unique case (state_q)
      c_idle, c_done: begin
        if (start) begin
          state_d = c_load;
          idx_d   = 4'd0;
        end
      end
      c_load: begin
        if (w_handshake) begin
          prog_count_d = idx_q;
          data_in_d    = s_data[11:8];
          prog_inst_d  = s_data[7:4];
          prog_data_d  = s_data[3:0];
          idx_d        = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = c_flush;
          end
        end
      end
      c_flush: begin
        // One extra reset-held cycle so the CPU samples word 15.
        state_d   = c_run;
        run_cnt_d = 16'd0;
      end
      c_run: begin
        run_cnt_d = run_cnt_q + 16'd1;
        if (run_cnt_q == c_run_last) begin
          result_d = cpu_data_out;
          state_d  = c_done;
        end
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  // Control outputs decoded from the registered state.
  always_comb begin
    s_ready   = (state_q == c_load);
    cpu_reset = (state_q != c_run);
    busy      = (state_q == c_load) || (state_q == c_flush) || (state_q == c_run);
    done      = (state_q == c_done);
  end

  assign prog_count = prog_count_q;
  assign prog_inst  = prog_inst_q;
  assign prog_data  = prog_data_q;
  assign data_in    = data_in_q;
  assign result     = result_q;

endmodule

`default_nettype wire

// File: doc/four_bit_loader.md
# four_bit_loader

Hardware boot loader and run controller for the `four_bit_comp` 4-bit computer. It accepts a 16-word program/data image over a valid/ready stream. It writes the image into the CPU's instruction, operand and data memories while holding the CPU in reset, then releases reset and lets the CPU run for a fixed number of cycles. At the end of the run it re-asserts reset and captures the CPU's `data_out` as the result. It sits between a host-side stream source and the CPU's programming port.

## Interface
Parameters:
- `RUN_CYCLES`, default 32: number of cycles the CPU runs with reset deasserted. Legal range is 1..65535.

Ports:
- `clock`  in  1  single clock for loader and CPU.
- `reset`  in  1  synchronous, active-high; returns the loader to IDLE.
- `start`  in  1  level-sampled request to load and run; honoured only in IDLE or DONE.
- `s_valid`  in  1  image word valid.
- `s_ready`  out  1  loader accepts a word.
- `s_data`  in  12  image word: [11:8] data memory value, [7:4] instruction opcode, [3:0] instruction operand.
- `cpu_reset`  out  1  drives the CPU `reset`; high means program/hold.
- `prog_count`  out  4  CPU memory address being written.
- `prog_inst`  out  4  opcode for `prog_count`.
- `prog_data`  out  4  operand for `prog_count`.
- `data_in`  out  4  data memory value for `prog_count`.
- `cpu_data_out`  in  4  CPU `data_out`.
- `busy`  out  1  high in LOAD, FLUSH and RUN.
- `done`  out  1  high in DONE.
- `result`  out  4  `cpu_data_out` captured at the end of the run.

## Operation
- Reset values:
  - state = IDLE, `cpu_reset` = 1, `s_ready` = 0, `busy` = 0, `done` = 0.
  - `prog_count`, `prog_inst`, `prog_data`, `data_in` and `result` = 0.
  - Word index = 0, run counter = 0.
- The CPU writes its memories at `prog_count` on each rising edge while `cpu_reset` = 1. It ignores the programming inputs while `cpu_reset` = 0.
- All outputs are registered. `s_ready` and `cpu_reset` are decoded from the registered state.
- States:
  - IDLE: `cpu_reset` = 1, `s_ready` = 0. If `start` = 1 → LOAD with index = 0.
  - LOAD: `cpu_reset` = 1, `s_ready` = 1.
    - On each handshake (`s_valid` & `s_ready`), the word's fields go to `data_in`/`prog_inst`/`prog_data`, and `prog_count` takes the current index.
    - The index then increments as a 4-bit value.
    - The handshake with index = 15 moves to FLUSH. Index wraps to 0.
    - Without `s_valid`, the loader waits indefinitely and the outputs hold.
  - FLUSH: one cycle. `cpu_reset` = 1, `s_ready` = 0. This lets the CPU capture word 15. Next state is RUN with run counter = 0.
  - RUN: `cpu_reset` = 0. The run counter increments each cycle. When the counter equals `RUN_CYCLES`-1, that edge captures `result` from `cpu_data_out` and moves to DONE.
  - DONE: `cpu_reset` = 1, which freezes the CPU. `done` = 1, and `result` holds. If `start` = 1 → LOAD with index = 0; `done` clears on that transition.
- `start` is ignored in LOAD, FLUSH and RUN. Once started, a load is never aborted except by `reset`.
- The `prog_*` and `data_in` outputs hold their last written values outside LOAD. `result` changes only on entry to DONE or on `reset`.
- Reset mid-operation:
  - Asserting `reset` in any state goes to IDLE next edge with all reset values. The partial image is discarded.
  - `cpu_reset` returns to 1 in the cycle after the `reset` edge.

## Timing
- Let edge t0 be the edge that samples `start` in IDLE or DONE.
- `s_ready` rises after t0. With `s_valid` held high, handshakes occur at edges t0+1..t0+16, one word per cycle.
- Word k's programming outputs are valid during the cycle after its handshake, and the CPU samples them at the next edge.
- FLUSH occupies t0+16..t0+17. `cpu_reset` falls after edge t0+17.
- `done` rises after edge t0+17+`RUN_CYCLES`. `cpu_reset` is low for exactly `RUN_CYCLES` cycles.
- Stall cycles (`s_valid` = 0 in LOAD) add one cycle each to the timeline.
- A `start` held high through DONE restarts immediately; there is one DONE cycle minimum.

## Test plan
- Reset then idle:
  - Drive `reset` = 1 for 2 cycles, then 0 with `start` = 0 and `s_valid` = 1.
  - Required: `cpu_reset` = 1, `s_ready` = 0, `busy` = 0, `done` = 0, all data outputs 0, and no handshake for 20 cycles.
- Streaming load:
  - Pulse `start`, then stream words k = 0..15 with `s_data` = {k, ~k, k^4'hA} and `s_valid` always high.
  - Required: `prog_count` steps 0..15 on consecutive cycles with matching fields.
  - Required: `cpu_reset` stays 1 through FLUSH, and `s_ready` is high for exactly 16 cycles.
- Stalled load:
  - Same image with `s_valid` toggling 1,0,0,1,...
  - Required: outputs hold during stalls, `prog_count` never skips or repeats, and FLUSH is entered only after the 16th handshake.
- Run length and result capture:
  - Use `RUN_CYCLES` = 32 and a stub driving `cpu_data_out` = run counter[3:0].
  - Required: `cpu_reset` is low for exactly 32 cycles, `done` rises at t0+49 with no stalls, and `result` = 4'hF.
- Integration with `four_bit_comp`:
  - Image data[0] = 3, data[1] = 5, others 0.
  - Program: MOV_A_ADD 0, XCHG_B_A, MOV_A_ADD 1, ADD_A_B, SUB_A_B, OUT_A, HLT, remaining words opcode 0.
  - Required: `result` = 4'd5 and `done` = 1.
- Reset mid-operation and restart:
  - Assert `reset` after the 7th handshake, then reload the full image with `start` held high.
  - Required: IDLE values on the edge after `reset`, and `prog_count` restarts at 0.
  - Required: after DONE, a held `start` re-enters LOAD after exactly one DONE cycle, and `done` clears.
